// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared next-PC command encodings and branch offset helper
package pc_sequencer_pkg;

  localparam logic [2:0] NPC_PLUS4  = 3'd0;
  localparam logic [2:0] NPC_BRANCH = 3'd1;
  localparam logic [2:0] NPC_JUMP   = 3'd2;
  localparam logic [2:0] NPC_JR     = 3'd3;
  localparam logic [2:0] NPC_EXCEPT = 3'd4;

  // Word offset of a branch: sign-extended imm16 scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/npc_calc.sv
// rtl/npc_calc.sv - combinational next-PC selection; misaligned targets trap when PC_SEQ_ALIGN_CHK_EN is defined
module npc_calc
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = 32'h0000_4180
) (
  input  logic [31:0] pc,
  input  logic [2:0]  npc_op,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] rs_data,
  output logic [31:0] npc,
  output logic        take_exc
);

  logic [31:0] pc_plus4;
  logic [31:0] raw_npc;
  logic        raw_exc;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    raw_npc = pc_plus4;
    raw_exc = 1'b0;
    case (npc_op)
      NPC_BRANCH: raw_npc = pc_plus4 + branch_offset(imm16);
      NPC_JUMP:   raw_npc = {pc_plus4[31:28], target26, 2'b00};
      NPC_JR:     raw_npc = rs_data;
      NPC_EXCEPT: begin
        raw_npc = EXC_VEC;
        raw_exc = 1'b1;
      end
      default:    raw_npc = pc_plus4;
    endcase
  end

`ifdef PC_SEQ_ALIGN_CHK_EN
  always_comb begin
    npc      = raw_npc;
    take_exc = raw_exc;
    if (raw_npc[1:0] != 2'b00) begin
      npc      = EXC_VEC;
      take_exc = 1'b1;
    end
  end
`else
  // Without the check, low address bits are simply dropped.
  always_comb begin
    npc      = raw_npc & 32'hFFFF_FFFC;
    take_exc = raw_exc;
  end
`endif

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/decode sequencer owning PC, instruction and EPC registers
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  NPCOp,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] rs_data,
  output logic [31:0] epc,
  output logic        exc
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] epc_q, epc_d;
  logic        exc_q, exc_d;

  logic [31:0] npc;
  logic        npc_exc;

  npc_calc #(
    .EXC_VEC (EXC_VEC)
  ) u_npc_calc (
    .pc       (pc_q),
    .npc_op   (NPCOp),
    .imm16    (imm16),
    .target26 (target26),
    .rs_data  (rs_data),
    .npc      (npc),
    .take_exc (npc_exc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      epc_q   <= 32'd0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      epc_q   <= epc_d;
      exc_q   <= exc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    epc_d   = epc_q;
    exc_d   = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_valid) begin
          pc_d    = npc;
          state_d = S_FETCH;
          if (npc_exc) begin
            epc_d = pc_q;
            exc_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decode state only, so op_valid never reaches imem_req.
  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_DECODE);
  assign op_ready    = (state_q == S_DECODE);
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign epc         = epc_q;
  assign exc         = exc_q;

endmodule
